scope_value_accum: RTL and testbench
====================================

SCOPE_VALUE_ACCUM -- requirements
Module: scope_value_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width of input samples and the output sum.
REQ-002 The block SHALL have parameter NSAMP, default 4, the number of samples per frame; legal range 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning an upstream sample is offered.
REQ-006 The block SHALL have port in_data, input, WIDTH bits, the sample value, typically the constant-output scope module's o1.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning a frame result is held.
REQ-009 The block SHALL have port out_ready, input, 1 bit, the downstream accept signal.
REQ-010 The block SHALL have port out_data, output, WIDTH bits, the saturated frame sum.
REQ-011 The block SHALL have port out_sat, output, 1 bit, set when saturation occurred in the held frame.
REQ-012 The block SHALL have port out_frames, output, 8 bits, the count of completed output handshakes.

Function
REQ-013 The FSM SHALL have two states, ACCUM and HOLD, and SHALL enter ACCUM on reset.
REQ-014 ACCUM: in_ready=1, out_valid=0; HOLD: in_ready=0, out_valid=1 (both registered or purely state-decoded; no combinational path from in_valid or out_ready to in_ready).
REQ-015 An accept SHALL be defined as in_valid && in_ready; each accept SHALL add in_data to acc and increment cnt (8-bit).
REQ-016 The addition SHALL be computed at WIDTH+1 bits; if the carry is set, acc SHALL become 2^WIDTH-1 and a sticky sat flag SHALL set for the frame.
REQ-017 Once acc is all-ones, it SHALL remain all-ones for the rest of the frame, and sat SHALL stay set.
REQ-018 On the accept where cnt==NSAMP-1, the FSM SHALL go to HOLD, with out_data equal to the final sum (including that sample) and out_sat equal to the final flag.
REQ-019 out_valid SHALL therefore rise exactly one cycle after the NSAMP-th accept.
REQ-020 In HOLD, out_data and out_sat SHALL be stable until out_valid && out_ready.
REQ-021 On the output handshake, the block SHALL clear acc, cnt and sat, increment out_frames modulo 256 (255 -> 0), and return to ACCUM the next cycle.
REQ-022 The block SHALL NOT accept a sample in the same cycle as the output handshake; the first new accept is possible in the following cycle.
REQ-023 in_data SHALL be ignored whenever no accept occurs.
REQ-024 out_ready SHALL be ignored in ACCUM.
REQ-025 out_data SHALL show the running acc while in ACCUM; its value is don't-care for consumers while out_valid=0.

Reset
REQ-026 Asserting rst SHALL asynchronously force: state=ACCUM, acc=0, cnt=0, sat=0, out_frames=0, out_valid=0, out_data=0, out_sat=0.
REQ-027 While rst is asserted, in_ready SHALL be 0.
REQ-028 After rst deasserts, in_ready SHALL become 1 on the first clk edge.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial or held frame with no output handshake and no out_frames increment.

Verification
REQ-030 The bench SHALL cover: in_data=11, in_valid=1 continuously, out_ready=1, NSAMP=4 -> out_valid one cycle after the 4th accept, out_data=44, out_sat=0, out_frames 0->1.
REQ-031 The bench SHALL cover: samples 0xFFFFFFF0, 0x20, 5, 7 -> out_data=0xFFFFFFFF, out_sat=1; next frame of 1,1,1,1 -> out_data=4, out_sat=0.
REQ-032 The bench SHALL cover: frame complete with out_ready=0 for 3 cycles -> out_valid=1, out_data stable, in_ready=0 throughout; the handshake occurs on cycle 4.
REQ-033 The bench SHALL cover: in_valid toggling 1,0,1,0,... with samples 2,3,4,5 -> out_data=14, with invalid-cycle data ignored.
REQ-034 The bench SHALL cover: rst pulse after 2 accepts, then 4 samples of 1 -> out_data=4 and out_frames=1.
REQ-035 The bench SHALL cover: 256 consecutive frames -> out_frames wraps to 0, and all frame sums are correct.

Source files
------------

// File: rtl/scope_value_accum.sv
// Frame accumulator: sums NSAMP accepted samples with WIDTH-bit saturation,
// then holds the result until the downstream handshake.
module scope_value_accum #(
  parameter int WIDTH = 32,
  parameter int NSAMP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic [7:0]       out_frames
);

  // state | meaning
  // ACCUM | accepting samples into acc, cnt counts accepts in this frame
  // HOLD  | frame result held on out_data/out_sat until out_ready
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [7:0] LAST = 8'(NSAMP - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       frames_q, frames_d;
  logic             sat_q, sat_d;
  logic             rdy_q;
  logic [WIDTH:0]   sum;
  logic             accept;

  // rdy_q is held low in reset and rises on the first edge afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
      sat_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      sat_q    <= sat_d;
      rdy_q    <= (state_d == ACCUM);
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    sat_d    = sat_q;
    sum      = {1'b0, acc_q} + {1'b0, in_data};
    accept   = in_valid && rdy_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          // an all-ones acc plus any nonzero sample carries, so it stays saturated
          if (sum[WIDTH]) begin
            acc_d = '1;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[WIDTH-1:0];
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d    = '0;
          cnt_d    = '0;
          sat_d    = 1'b0;
          frames_d = frames_q + 8'd1;
          state_d  = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign in_ready   = rdy_q;
  assign out_valid  = (state_q == HOLD);
  assign out_data   = acc_q;
  assign out_sat    = sat_q;
  assign out_frames = frames_q;

endmodule

// File: tb/tb_scope_value_accum.sv
// Randomized bench for scope_value_accum against a saturating frame-sum model.
module tb_scope_value_accum;
  localparam int WIDTH = 32;
  localparam int NSAMP = 4;
  localparam logic [63:0] MAXV = 64'h0000_0000_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;
  logic [7:0]       out_frames;

  int tests_run = 0;
  int failed = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  scope_value_accum #(.WIDTH(WIDTH), .NSAMP(NSAMP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_frames(out_frames)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entered and left at 1 time unit after a rising edge. gap alternates
  // valid/invalid cycles; hold is the number of HOLD cycles with out_ready=0.
  task automatic run_frame(input logic [31:0] s [NSAMP], input int gap, input int hold);
    logic [63:0] total = 0;
    logic [31:0] exp_run, exp_sum;
    logic        exp_sat;
    int          idx = 0;
    int          cyc = 0;
    bit          v;
    bit          phase = 0;
    while (idx < NSAMP && cyc < 200) begin
      v = gap ? !phase : 1'b1;
      phase = !phase;
      in_valid  = v;
      in_data   = v ? s[idx] : $urandom;
      out_ready = 1'($urandom_range(0, 1));
      exp_run = (total > MAXV) ? 32'hFFFF_FFFF : total[31:0];
      tests_run++;
      if (out_data !== exp_run) begin
        failed++;
        $display("FAIL running_acc: got %0h expected %0h", out_data, exp_run);
      end
      if (v && in_ready) begin
        total = total + {32'd0, s[idx]};
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (idx != NSAMP) begin
      failed++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", idx, NSAMP);
      return;
    end
    in_valid  = 1'b1;
    in_data   = $urandom;
    out_ready = (hold == 0);
    exp_sum = (total > MAXV) ? 32'hFFFF_FFFF : total[31:0];
    exp_sat = (total > MAXV);
    for (int c = 0; c < ((hold > 0) ? hold : 1); c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        in_data = $urandom;
      end
      tests_run++;
      if (out_valid !== 1'b1) begin
        failed++;
        $display("FAIL hold_valid[%0d]: got %b expected 1", c, out_valid);
      end
      tests_run++;
      if (in_ready !== 1'b0) begin
        failed++;
        $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, in_ready);
      end
      tests_run++;
      if (out_data !== exp_sum) begin
        failed++;
        $display("FAIL frame_sum[%0d]: got %0h expected %0h", c, out_data, exp_sum);
      end
      tests_run++;
      if (out_sat !== exp_sat) begin
        failed++;
        $display("FAIL frame_sat[%0d]: got %b expected %b", c, out_sat, exp_sat);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_frames = (exp_frames + 1) % 256;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL after_hs: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    tests_run++;
    if (out_frames !== 8'(exp_frames)) begin
      failed++;
      $display("FAIL out_frames: got %0d expected %0d", out_frames, exp_frames);
    end
    tests_run++;
    if (out_data !== 32'd0 || out_sat !== 1'b0) begin
      failed++;
      $display("FAIL cleared_after_hs: got data=%0h sat=%b expected 0 0", out_data, out_sat);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    exp_frames = 0;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
        out_sat !== 1'b0 || out_frames !== 8'd0) begin
      failed++;
      $display("FAIL reset_state: got ready=%b valid=%b data=%0h sat=%b frames=%0d expected all 0",
               in_ready, out_valid, out_data, out_sat, out_frames);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      failed++;
      $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failed++;
      $display("FAIL ready_after_edge: got ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_frames !== 8'd0) begin
      failed++;
      $display("FAIL initial_reset: got ready=%b valid=%b frames=%0d expected 0 0 0",
               in_ready, out_valid, out_frames);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [31:0] s [NSAMP];
    foreach (s[i]) s[i] = 32'd11;
    run_frame(s, 0, 0);
  endtask

  task automatic test_saturation();
    logic [31:0] s [NSAMP];
    s[0] = 32'hFFFF_FFF0; s[1] = 32'h20; s[2] = 32'd5; s[3] = 32'd7;
    run_frame(s, 0, 0);
    foreach (s[i]) s[i] = 32'd1;
    run_frame(s, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] s [NSAMP];
    foreach (s[i]) s[i] = $urandom_range(0, 100000);
    run_frame(s, 0, 3);
  endtask

  task automatic test_gaps();
    logic [31:0] s [NSAMP];
    s[0] = 32'd2; s[1] = 32'd3; s[2] = 32'd4; s[3] = 32'd5;
    run_frame(s, 1, 0);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] s [NSAMP];
    in_valid = 1'b1; in_data = 32'd7;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    do_reset();
    tests_run++;
    if (out_data !== 32'd0 || out_frames !== 8'd0) begin
      failed++;
      $display("FAIL midframe_discard: got data=%0h frames=%0d expected 0 0", out_data, out_frames);
    end
    in_valid = 1'b1; in_data = 32'd9;
    repeat (NSAMP) @(posedge clk);
    #1 in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'd36) begin
      failed++;
      $display("FAIL hold_before_reset: got valid=%b data=%0d expected 1 36", out_valid, out_data);
    end
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0 || out_frames !== 8'd0) begin
      failed++;
      $display("FAIL hold_discard: got valid=%b frames=%0d expected 0 0", out_valid, out_frames);
    end
    foreach (s[i]) s[i] = 32'd1;
    run_frame(s, 0, 0);
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] s [NSAMP];
    do_reset();
    for (int f = 0; f < 256; f++) begin
      foreach (s[i]) s[i] = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1000);
      run_frame(s, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end
    tests_run++;
    if (out_frames !== 8'd0) begin
      failed++;
      $display("FAIL frames_wrap: got %0d expected 0", out_frames);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_gaps();
    test_reset_midframe();
    test_back_to_back_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
